// File: rtl/bin_to_gray.sv
// Binary-to-Gray converter: combinational gray_o, plus a registered copy with a single-bit-step monitor.
// Latency: gray_o 0 cycles; gray_q/valid_q/step_err_o 1 cycle. No backpressure; valid_i only qualifies samples.
module bin_to_gray #(
   parameter int WIDTH = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] bin_i,
   input  logic             valid_i,
   output logic [WIDTH-1:0] gray_o,
   output logic [WIDTH-1:0] gray_q,
   output logic             valid_q,
   output logic             step_err_o
);

   logic             have_prev;
   logic [WIDTH-1:0] step_diff;
   logic             single_bit;

   assign gray_o = bin_i ^ (bin_i >> 1);

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   assign step_diff  = gray_o ^ gray_q;
   assign single_bit = (step_diff != '0) && ((step_diff & (step_diff - WIDTH'(1))) == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         gray_q     <= '0;
         valid_q    <= 1'b0;
         step_err_o <= 1'b0;
         have_prev  <= 1'b0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            gray_q     <= gray_o;
            have_prev  <= 1'b1;
            step_err_o <= have_prev && !single_bit;
         end
      end
   end

endmodule

// File: tb/tb_bin_to_gray.sv
// Directed bench for bin_to_gray: per-cycle model comparison plus literal checkpoints.
module tb_bin_to_gray;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] bin5  = '0;
   logic       vld5  = 1'b0;
   logic [4:0] g5, gq5;
   logic       vq5, err5;
   logic [0:0] bin1  = '0;
   logic [0:0] g1, gq1;
   logic       vq1, err1;
   logic [7:0] bin8  = '0;
   logic [7:0] g8, gq8;
   logic       vq8, err8;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clock = ~clock;

   bin_to_gray #(.WIDTH(5)) dut5 (
      .clock(clock), .reset(reset), .bin_i(bin5), .valid_i(vld5),
      .gray_o(g5), .gray_q(gq5), .valid_q(vq5), .step_err_o(err5)
   );
   bin_to_gray #(.WIDTH(1)) dut1 (
      .clock(clock), .reset(reset), .bin_i(bin1), .valid_i(1'b0),
      .gray_o(g1), .gray_q(gq1), .valid_q(vq1), .step_err_o(err1)
   );
   bin_to_gray #(.WIDTH(8)) dut8 (
      .clock(clock), .reset(reset), .bin_i(bin8), .valid_i(1'b0),
      .gray_o(g8), .gray_q(gq8), .valid_q(vq8), .step_err_o(err8)
   );

   // Bit rule: g[i] = b[i] ^ b[i+1], top bit copied.
   function automatic logic [31:0] gray_model(input logic [31:0] b, input int w);
      logic [31:0] g = '0;
      for (int i = 0; i < w; i++)
         g[i] = (i == w - 1) ? b[i] : (b[i] ^ b[i+1]);
      return g;
   endfunction

   // Inverse: running XOR from the MSB downwards.
   function automatic logic [31:0] gray_inverse(input logic [31:0] g, input int w);
      logic [31:0] b = '0;
      b[w-1] = g[w-1];
      for (int i = w - 2; i >= 0; i--)
         b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model of the registered path.
   logic [4:0] m_gq = '0;
   logic       m_vq = 1'b0, m_err = 1'b0, m_have = 1'b0;

   always @(posedge clock) begin
      logic [4:0] g;
      if (reset) begin
         m_gq <= '0; m_vq <= 1'b0; m_err <= 1'b0; m_have <= 1'b0;
      end else begin
         m_vq <= vld5;
         if (vld5) begin
            g = 5'(gray_model({27'b0, bin5}, 5));
            m_gq   <= g;
            m_err  <= m_have && ($countones(g ^ m_gq) != 1);
            m_have <= 1'b1;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("cmp_gray_o",  {27'b0, g5},   gray_model({27'b0, bin5}, 5));
         chk("cmp_gray_q",  {27'b0, gq5},  {27'b0, m_gq});
         chk("cmp_valid_q", {31'b0, vq5},  {31'b0, m_vq});
         chk("cmp_step_err",{31'b0, err5}, {31'b0, m_err});
      end
   end

   task automatic cyc(input logic [4:0] b, input logic v);
      bin5 = b;
      vld5 = v;
      @(posedge clock);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [4:0] lit_bin [7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd10, 5'd31};
   logic [4:0] lit_gry [7] = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00111, 5'b01111, 5'b10000};

   initial begin
      // Reset values, gray_o unaffected by reset.
      reset = 1'b1;
      cyc(5'd7, 1'b1);
      chk_en = 1'b1;
      chk("rst_gray_q",  {27'b0, gq5}, 32'h0);
      chk("rst_valid_q", {31'b0, vq5}, 32'h0);
      chk("rst_err",     {31'b0, err5}, 32'h0);
      chk("rst_gray_o",  {27'b0, g5}, 32'b00100);
      reset = 1'b0;

      // Literal Gray values pin the model.
      for (int k = 0; k < 7; k++) begin
         bin5 = lit_bin[k];
         #1;
         chk("lit_gray_o", {27'b0, g5}, {27'b0, lit_gry[k]});
      end

      // Increment through two full wraps; model checks step_err each cycle.
      for (int i = 0; i <= 64; i++) begin
         cyc(5'(i), 1'b1);
         if (i == 10) chk("inc_gray_q_10", {27'b0, gq5}, 32'b01111);
         if (i == 32) chk("wrap_err", {31'b0, err5}, 32'h0);
      end
      chk("inc_err_end", {31'b0, err5}, 32'h0);

      // Valid gating: gray_q holds while bin changes.
      cyc(5'd4, 1'b1);
      chk("gate_gray_q4", {27'b0, gq5}, 32'b00110);
      chk("gate_err_jump", {31'b0, err5}, 32'h1);
      cyc(5'd9, 1'b0);
      cyc(5'd9, 1'b0);
      chk("gate_gray_q_hold", {27'b0, gq5}, 32'b00110);
      chk("gate_valid_q", {31'b0, vq5}, 32'h0);
      chk("gate_err_hold", {31'b0, err5}, 32'h1);

      // Step error detection.
      cyc(5'd3, 1'b1);
      chk("step_ok_3", {31'b0, err5}, 32'h0);
      cyc(5'd5, 1'b1);
      chk("step_err_5", {31'b0, err5}, 32'h1);
      cyc(5'd4, 1'b1);
      chk("step_ok_4", {31'b0, err5}, 32'h0);

      // Reset mid-stream.
      cyc(5'd12, 1'b1);
      reset = 1'b1;
      cyc(5'd12, 1'b0);
      reset = 1'b0;
      cyc(5'd20, 1'b1);
      chk("mid_err", {31'b0, err5}, 32'h0);
      chk("mid_gray_q", {27'b0, gq5}, 32'b11110);
      cyc(5'd20, 1'b1);
      chk("repeat_err", {31'b0, err5}, 32'h1);
      cyc(5'd21, 1'b0);

      // Exhaustive combinational checks for widths 1, 5 and 8.
      chk_en = 1'b0;
      for (int v = 0; v < 2; v++) begin
         bin1 = 1'(v);
         #1;
         chk("w1_gray", {31'b0, g1}, gray_model(32'(v), 1));
         chk("w1_inv", gray_inverse({31'b0, g1}, 1), 32'(v));
      end
      for (int v = 0; v < 32; v++) begin
         bin5 = 5'(v);
         #1;
         chk("w5_gray", {27'b0, g5}, gray_model(32'(v), 5));
         chk("w5_inv", gray_inverse({27'b0, g5}, 5), 32'(v));
      end
      for (int v = 0; v < 256; v++) begin
         bin8 = 8'(v);
         #1;
         chk("w8_gray", {24'b0, g8}, gray_model(32'(v), 8));
         chk("w8_inv", gray_inverse({24'b0, g8}, 8), 32'(v));
      end
      chk("w8_lit_ff", {24'b0, g8}, 32'h80);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
